// File: rtl/reaction_timer.sv
// Reaction-trial controller: random pre-GO delay, millisecond reaction count,
// false-start detection. The result drives the 4-digit display number input.
module reaction_timer #(
    parameter int CLKS_PER_MS  = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_COUNT    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        react,
    output logic [13:0] number,
    output logic        go_led,
    output logic        done,
    output logic        false_start,
    output logic        busy
);

    // state   | meaning
    // S_IDLE  | after reset, waiting for start
    // S_WAIT  | random delay running, GO lamp off
    // S_GO    | GO lamp on, counting milliseconds
    // S_DONE  | valid reaction or timeout, result held
    // S_FALSE | react pressed before GO, result 0
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_FALSE
    } state_t;

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam logic [13:0] MAX_NUM = 14'(MAX_COUNT);

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     lfsr;
    logic [PW-1:0]   prescale;
    logic [DW-1:0]   delay_cnt;
    logic [DW-1:0]   delay_nxt;
    logic [DW-1:0]   delay_load;
    logic [13:0]     number_nxt;
    logic [13:0]     number_inc;
    logic            tick;

    always_comb begin
        tick       = (prescale == PW'(CLKS_PER_MS - 1));
        delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
        number_inc = number + 14'd1;
    end

    always_comb begin
        state_nxt  = state;
        delay_nxt  = delay_cnt;
        number_nxt = number;
        case (state)
            S_IDLE, S_DONE, S_FALSE: begin
                if (start) begin
                    state_nxt  = S_WAIT;
                    delay_nxt  = delay_load;
                    number_nxt = 14'd0;
                end
            end
            S_WAIT: begin
                // react beats the final tick: pressing on that edge is still early
                if (react) begin
                    state_nxt = S_FALSE;
                end else if (tick) begin
                    delay_nxt = delay_cnt - DW'(1);
                    if (delay_cnt == DW'(1)) begin
                        state_nxt = S_GO;
                    end
                end
            end
            S_GO: begin
                if (react) begin
                    state_nxt = S_DONE;
                end else if (tick) begin
                    number_nxt = number_inc;
                    if (number_inc == MAX_NUM) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            lfsr        <= 16'hACE1;
            prescale    <= '0;
            delay_cnt   <= '0;
            number      <= 14'd0;
            go_led      <= 1'b0;
            done        <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
            number    <= number_nxt;
            lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            // restart the ms grid on every state entry
            if ((state_nxt != state) || tick) begin
                prescale <= '0;
            end else begin
                prescale <= prescale + PW'(1);
            end
            go_led      <= (state_nxt == S_GO);
            done        <= (state_nxt == S_DONE);
            false_start <= (state_nxt == S_FALSE);
            busy        <= (state_nxt == S_WAIT) || (state_nxt == S_GO);
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed trials plus random start/react/reset
// traffic, every cycle compared against a millisecond-level trial model.
module tb_reaction_timer;

    localparam int CPM    = 4;
    localparam int MIN_MS = 3;
    localparam int RB     = 2;
    localparam int MAXC   = 20;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_GO    = 2;
    localparam int P_DONE  = 3;
    localparam int P_FALSE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [13:0] number;
    logic        go_led;
    logic        done;
    logic        false_start;
    logic        busy;

    always #5 clk = ~clk;

    reaction_timer #(
        .CLKS_PER_MS (CPM),
        .MIN_DELAY_MS(MIN_MS),
        .RAND_BITS   (RB),
        .MAX_COUNT   (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .react      (react),
        .number     (number),
        .go_led     (go_led),
        .done       (done),
        .false_start(false_start),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    int          m_phase  = P_IDLE;
    int          m_entry  = 0;
    int          m_delay  = 0;
    int          m_number = 0;
    logic [15:0] m_lfsr   = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_entry = cyc_n;
    endtask

    // Trial model in milliseconds: ms boundaries fall every CPM cycles after entry.
    task automatic model_edge(input logic r_n, input logic s, input logic r);
        int  el;
        bit  tick;
        el   = cyc_n - m_entry;
        tick = (el > 0) && (el % CPM == 0);
        if (!r_n) begin
            enter(P_IDLE);
            m_number = 0;
            m_lfsr   = 16'hACE1;
        end else begin
            case (m_phase)
                P_WAIT: begin
                    if (r) enter(P_FALSE);
                    else if (tick && (el / CPM == m_delay)) enter(P_GO);
                end
                P_GO: begin
                    if (r) enter(P_DONE);
                    else if (tick) begin
                        m_number = el / CPM;
                        if (m_number >= MAXC) begin
                            m_number = MAXC;
                            enter(P_DONE);
                        end
                    end
                end
                default: begin
                    if (s) begin
                        m_delay  = MIN_MS + int'(m_lfsr[RB-1:0]);
                        m_number = 0;
                        enter(P_WAIT);
                    end
                end
            endcase
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic cyc(input logic r_n, input logic s, input logic r);
        logic [3:0] exp_flags;
        rst   = r_n;
        start = s;
        react = r;
        @(posedge clk);
        cyc_n++;
        model_edge(r_n, s, r);
        #1;
        exp_flags = {m_phase == P_GO, m_phase == P_DONE, m_phase == P_FALSE,
                     (m_phase == P_WAIT) || (m_phase == P_GO)};
        chk("flags", int'({go_led, done, false_start, busy}), int'(exp_flags));
        chk("number", int'(number), m_number);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_go(output int n);
        n = 0;
        while (!go_led && n < 100) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!go_led) chk("go_timeout", int'(go_led), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!done) chk("done_timeout", int'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          d;
        logic [15:0] l_at;

        // 1: reset, including from mid-trial
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("lfsr_reset", int'(dut.lfsr), 16'hACE1);
        cyc(1'b1, 1'b1, 1'b0);
        idle(10);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("reset_flags", int'({go_led, done, false_start, busy}), 0);
        chk("reset_number", int'(number), 0);
        chk("lfsr_reset2", int'(dut.lfsr), 16'hACE1);

        // 2: normal trial with lfsr[1:0]==2, react 29 cycles after GO
        n = 0;
        while (m_lfsr[1:0] != 2'd2 && n < 40) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        l_at = m_lfsr;
        cyc(1'b1, 1'b1, 1'b0);
        chk("busy_after_start", int'(busy), 1);
        wait_go(n);
        chk("go_latency", n, CPM * (MIN_MS + int'(l_at[RB-1:0])));
        idle(4 * 7);
        cyc(1'b1, 1'b0, 1'b1);
        chk("react_number", int'(number), 7);
        chk("react_done", int'({done, go_led}), 2'b10);
        idle(50);
        chk("held_number", int'(number), 7);

        // 3: false start 5 cycles after start, then restart
        cyc(1'b1, 1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b0, 1'b1);
        chk("false_flag", int'(false_start), 1);
        chk("false_number", int'(number), 0);
        idle(30);
        chk("false_no_go", int'(go_led), 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("restart_flags", int'({busy, false_start}), 2'b10);

        // 4: timeout with saturation
        wait_go(n);
        wait_done();
        chk("timeout_number", int'(number), MAXC);
        idle(20);
        chk("timeout_hold", int'(number), MAXC);

        // 5a: react coincident with the tick that would make 6
        cyc(1'b1, 1'b1, 1'b0);
        wait_go(n);
        idle(23);
        cyc(1'b1, 1'b0, 1'b1);
        chk("react_on_tick", int'(number), 5);

        // 5b: react on the final WAIT tick
        l_at = m_lfsr;
        cyc(1'b1, 1'b1, 1'b0);
        d = MIN_MS + int'(l_at[RB-1:0]);
        idle(CPM * d - 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("final_tick_false", int'({false_start, go_led}), 2'b10);

        // 6: reset mid-GO, then a normal trial
        cyc(1'b1, 1'b1, 1'b0);
        wait_go(n);
        idle(37);
        chk("mid_go_number", int'(number), 9);
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid_go_reset_number", int'(number), 0);
        chk("mid_go_reset_flags", int'({go_led, done, false_start, busy}), 0);
        cyc(1'b1, 1'b1, 1'b0);
        wait_go(n);
        idle(10);
        cyc(1'b1, 1'b0, 1'b1);
        chk("post_reset_trial", int'(number), 2);

        // random traffic at several react rates
        for (int seg = 0; seg < 4; seg++) begin
            int rate;
            rate = (seg == 0) ? 6 : (seg == 1) ? 30 : (seg == 2) ? 120 : 400;
            for (int i = 0; i < 600; i++) begin
                cyc(($urandom % 400) != 0, ($urandom % 8) == 0, ($urandom % rate) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
Game-control stage that runs one reaction trial and produces the 14-bit millisecond result consumed by the 4-digit seven-segment display block. After start, it waits a pseudo-random delay and then raises the GO lamp. It counts whole milliseconds until the player presses react, and flags presses made before GO as false starts. The number output drives the display's number input directly.

Parameters:
CLKS_PER_MS, 100000, clk cycles per 1 ms tick (100 MHz board clock)
MIN_DELAY_MS, 1000, fixed part of the pre-GO delay in ms
RAND_BITS, 11, width of the random extra delay (0..2^RAND_BITS-1 ms)
MAX_COUNT, 9999, saturation and timeout value of the result

Ports:
clk  input  1  system clock; the only clock in the block
rst  input  1  synchronous, active-low reset, sampled on posedge clk
start  input  1  one-cycle debounced pulse that begins a trial
react  input  1  one-cycle debounced pulse from the player button
number  output  14  result in ms, 0..MAX_COUNT, to the display block
go_led  output  1  high while in GO
done  output  1  high while in DONE (valid reaction or timeout)
false_start  output  1  high while in FALSE
busy  output  1  high in WAIT or GO

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; number=0; all flags 0.
  - Prescaler and delay counter cleared.
  - LFSR loaded with 16'hACE1.
  - Reset overrides any state mid-trial.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle out of reset regardless of state.
- ms tick: prescaler counts 0..CLKS_PER_MS-1. tick=1 in the cycle the prescaler equals CLKS_PER_MS-1, then the prescaler wraps to 0. The prescaler is cleared on every state entry, so the first tick arrives CLKS_PER_MS cycles after entry.
- All outputs are registered and are pure functions of state, except number.
- IDLE:
  - start -> WAIT.
  - On that transition: delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] (current LFSR value), and number=0.
  - react is ignored.
- WAIT:
  - react -> FALSE. number stays 0.
  - Otherwise, on each tick delay_cnt decrements. When a tick occurs with delay_cnt==1, next state is GO.
  - react has priority over a simultaneous final tick, which makes the cycle a false start.
  - start is ignored.
- GO:
  - react -> DONE, and number is frozen at its current value.
  - Otherwise, on each tick number increments. If the increment makes number==MAX_COUNT, next state is DONE (timeout) with number=MAX_COUNT.
  - react wins over a simultaneous tick, so no increment occurs that cycle.
  - start is ignored.
- DONE: number held. start -> WAIT, with the same load as from IDLE.
- FALSE: number held at 0. start -> WAIT, with the same load as from IDLE.
- Latency: a react sampled at posedge N gives go_led=0 and done=1 from posedge N onward (visible in cycle N+1).
- Width rules:
  - delay_cnt is wide enough for MIN_DELAY_MS + 2^RAND_BITS - 1.
  - number never exceeds MAX_COUNT and never wraps.
  - MIN_DELAY_MS must be >= 1.

Test Plan:
All scenarios use CLKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2, MAX_COUNT=20.
1. Hold rst=0 for 3 cycles from arbitrary state -> state IDLE, number=0, go_led=done=false_start=busy=0. First post-reset LFSR value = 16'hACE1.
2. Pulse start with lfsr[1:0] known (e.g. 2) -> busy=1 immediately, and go_led rises exactly (3+2)*4=20 cycles after the WAIT entry edge. Pulse react 4*7+1 cycles after GO entry -> done=1, go_led=0, number=7, held through 50 idle cycles.
3. Pulse react 5 cycles after start -> false_start=1, number=0, go_led never asserts. Then start -> busy=1, false_start=0.
4. No react after GO -> number counts 1..20, one step per 4 cycles, then done=1 with number=20. Further ticks leave 20 unchanged.
5. In GO, assert react in the same cycle as a tick with number=5 -> final number=5, not 6. In WAIT, assert react on the final tick -> FALSE, not GO.
6. Drive rst=0 mid-GO with number=9 -> next cycle number=0, IDLE, flags 0. A following start begins a normal trial.
